// File: rtl/control_pkg.sv
// Shared decode types for the decode front end.
//   ctrl_t     : registered control bundle handed to EX
//   imm_src_t  : immediate format selector for sign_extend
//   OP_*       : RV32I major opcodes recognised by the decoder
//   ALU_OP_*   : coarse ALU class from main decode, refined by alu_decoder
//   ALU_*      : final ALU operation codes
//   MT_*       : memory access width codes
package control_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_PASSB = 2'b11;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] MT_BYTE = 2'b00;
  localparam logic [1:0] MT_HALF = 2'b01;
  localparam logic [1:0] MT_WORD = 2'b10;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_src_t;

  typedef struct packed {
    logic       result_src;   // 1: write-back from memory (load)
    logic       mem_write;
    logic       alu_src;      // 1: operand B is the immediate
    logic       reg_write;
    logic       jalr_pc_src;  // 1: target is rs1+imm rather than pc+imm
    logic       jstore;       // 1: write pc+4 to rd (JAL/JALR)
    logic [1:0] mem_type;
    logic       mem_sign;     // 1: sign-extend loaded data
    logic       branch;
    logic       jump;
    logic [3:0] alu_ctrl;
  } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Refines the coarse ALU class into a concrete ALU operation.
//   funct3   : instr[14:12]
//   funct7b5 : instr[30], selects sub/sra
//   op5      : opcode bit 5, separates R-type (sub legal) from I-type
//   alu_op   : class from main decode
//   alu_ctrl : ALU operation code
module alu_decoder
  import control_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  input  logic [1:0] alu_op,
  output logic [3:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    unique case (alu_op)
      ALU_OP_ADD:   alu_ctrl = ALU_ADD;
      ALU_OP_SUB:   alu_ctrl = ALU_SUB;
      ALU_OP_PASSB: alu_ctrl = ALU_PASSB;
      default: begin
        unique case (funct3)
          3'b000:  alu_ctrl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD; // addi never subtracts
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/instr_queue.sv
// Circular FIFO of {pc, instr} feeding decode.
//   push_i/pc_i/instr_i : write one entry (caller guarantees not full)
//   pop_i               : retire head (caller guarantees not empty)
//   flush_i             : empty the queue; overrides push/pop
//   head_pc_o/instr_o   : current head entry, combinational
//   count_o             : occupancy 0..DEPTH
module instr_queue #(
  parameter int AW    = 32,
  parameter int IW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [AW-1:0]              pc_i,
  input  logic [IW-1:0]              instr_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [AW-1:0]              head_pc_o,
  output logic [IW-1:0]              head_instr_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          wr_en;

  assign wr_en = push_i && !flush_i;

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= '{pc: pc_i, instr: instr_i};
  end

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + PW'(1);
      if (pop_i)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_o <= count_o + CW'(1);
        2'b01:   count_o <= count_o - CW'(1);
        default: count_o <= count_o;
      endcase
    end
  end

  assign head_pc_o    = mem[rd_ptr].pc;
  assign head_instr_o = mem[rd_ptr].instr;

endmodule

// File: rtl/sign_extend.sv
// Builds the 32-bit sign-extended immediate for each instruction format.
//   instr    : instr[31:7]
//   imm_src  : format selector
//   imm      : sign-extended immediate
module sign_extend
  import control_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_src_t    imm_src,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    unique case (imm_src)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      IMM_J: imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_pipe.sv
// Decoupled decode front end: fetch queue -> decode -> registered EX bundle.
//   fetch_valid_i/ready_o, fetch_pc_i, fetch_instr_i : fetch push side
//   flush_i                                          : redirect, empties queue and EX register
//   ex_ready_i/ex_valid_o                            : EX handshake
//   ex_pc_o, ex_ctrl_o, ex_imm_o, ex_rs1/rs2/rd_o    : decoded bundle
//   ex_illegal_o                                     : unrecognised opcode
//   q_count_o                                        : queue occupancy
// Branch/jump are flagged only; condition resolution happens in EX.
module decode_pipe
  import control_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       fetch_valid_i,
  output logic                       fetch_ready_o,
  input  logic [ADDR_WIDTH-1:0]      fetch_pc_i,
  input  logic [INSTR_WIDTH-1:0]     fetch_instr_i,
  input  logic                       flush_i,
  input  logic                       ex_ready_i,
  output logic                       ex_valid_o,
  output logic [ADDR_WIDTH-1:0]      ex_pc_o,
  output ctrl_t                      ex_ctrl_o,
  output logic [31:0]                ex_imm_o,
  output logic [4:0]                 ex_rs1_o,
  output logic [4:0]                 ex_rs2_o,
  output logic [4:0]                 ex_rd_o,
  output logic                       ex_illegal_o,
  output logic [$clog2(DEPTH+1)-1:0] q_count_o
);

  localparam int CW = $clog2(DEPTH+1);

  logic [ADDR_WIDTH-1:0]  head_pc;
  logic [INSTR_WIDTH-1:0] head_instr;
  logic                   push, pop, hazard, ex_is_load;

  assign fetch_ready_o = (q_count_o < CW'(DEPTH)) && !flush_i;
  assign push          = fetch_valid_i && fetch_ready_o;

  instr_queue #(
    .AW    (ADDR_WIDTH),
    .IW    (INSTR_WIDTH),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (push),
    .pc_i         (fetch_pc_i),
    .instr_i      (fetch_instr_i),
    .pop_i        (pop),
    .flush_i      (flush_i),
    .head_pc_o    (head_pc),
    .head_instr_o (head_instr),
    .count_o      (q_count_o)
  );

  // ---- head decode ----
  logic [6:0] op;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  assign op  = head_instr[6:0];
  assign rd  = head_instr[11:7];
  assign f3  = head_instr[14:12];
  assign rs1 = head_instr[19:15];
  assign rs2 = head_instr[24:20];

  ctrl_t      dec_base, dec_ctrl;
  imm_src_t   imm_src;
  logic [1:0] alu_op;
  logic [3:0] alu_ctrl_w;
  logic [31:0] dec_imm;
  logic       dec_illegal, uses_rs1, uses_rs2;

  always_comb begin
    dec_base    = '0;
    imm_src     = IMM_I;
    alu_op      = ALU_OP_ADD;
    dec_illegal = 1'b0;
    uses_rs1    = 1'b1;
    uses_rs2    = 1'b0;
    unique case (op)
      OP_LOAD: begin
        dec_base.reg_write  = 1'b1;
        dec_base.alu_src    = 1'b1;
        dec_base.result_src = 1'b1;
        dec_base.mem_type   = f3[1:0];
        dec_base.mem_sign   = !f3[2];
      end
      OP_STORE: begin
        dec_base.mem_write = 1'b1;
        dec_base.alu_src   = 1'b1;
        dec_base.mem_type  = f3[1:0];
        imm_src            = IMM_S;
        uses_rs2           = 1'b1;
      end
      OP_R: begin
        dec_base.reg_write = 1'b1;
        alu_op             = ALU_OP_FUNCT;
        uses_rs2           = 1'b1;
      end
      OP_I: begin
        dec_base.reg_write = 1'b1;
        dec_base.alu_src   = 1'b1;
        alu_op             = ALU_OP_FUNCT;
      end
      OP_BRANCH: begin
        dec_base.branch = 1'b1;
        imm_src         = IMM_B;
        alu_op          = ALU_OP_SUB;
        uses_rs2        = 1'b1;
      end
      OP_JAL: begin
        dec_base.reg_write = 1'b1;
        dec_base.jump      = 1'b1;
        dec_base.jstore    = 1'b1;
        imm_src            = IMM_J;
        uses_rs1           = 1'b0;
      end
      OP_JALR: begin
        dec_base.reg_write   = 1'b1;
        dec_base.jump        = 1'b1;
        dec_base.jstore      = 1'b1;
        dec_base.jalr_pc_src = 1'b1;
        dec_base.alu_src     = 1'b1;
      end
      OP_LUI: begin
        dec_base.reg_write = 1'b1;
        dec_base.alu_src   = 1'b1;
        imm_src            = IMM_U;
        alu_op             = ALU_OP_PASSB;
        uses_rs1           = 1'b0;
      end
      OP_AUIPC: begin
        dec_base.reg_write = 1'b1;
        dec_base.alu_src   = 1'b1;
        imm_src            = IMM_U;
        uses_rs1           = 1'b0;
      end
      default: dec_illegal = 1'b1; // rs1 still compared: stalling on junk is harmless
    endcase
  end

  alu_decoder u_alu_dec (
    .funct3   (f3),
    .funct7b5 (head_instr[30]),
    .op5      (op[5]),
    .alu_op   (alu_op),
    .alu_ctrl (alu_ctrl_w)
  );

  sign_extend u_sext (
    .instr   (head_instr[31:7]),
    .imm_src (imm_src),
    .imm     (dec_imm)
  );

  // alu_ctrl merged separately so the decoder output does not loop back
  // into the block that drives its inputs.
  always_comb begin
    dec_ctrl          = dec_base;
    dec_ctrl.alu_ctrl = dec_illegal ? 4'd0 : alu_ctrl_w;
  end

  // ---- load-use hazard ----
  assign ex_is_load = ex_valid_o && ex_ctrl_o.result_src && ex_ctrl_o.reg_write &&
                      (ex_rd_o != 5'd0);
  assign hazard     = ex_is_load && ((uses_rs1 && (rs1 == ex_rd_o)) ||
                                     (uses_rs2 && (rs2 == ex_rd_o)));

  assign pop = (q_count_o != '0) && (!ex_valid_o || ex_ready_i) && !hazard && !flush_i;

  // ---- EX register ----
  // A consumed load with a dependent head leaves pop low, so the register
  // falls to invalid for one cycle and the head issues on the next.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid_o   <= 1'b0;
      ex_pc_o      <= '0;
      ex_ctrl_o    <= '0;
      ex_imm_o     <= '0;
      ex_rs1_o     <= '0;
      ex_rs2_o     <= '0;
      ex_rd_o      <= '0;
      ex_illegal_o <= 1'b0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
    end else if (pop) begin
      ex_valid_o   <= 1'b1;
      ex_pc_o      <= head_pc;
      ex_ctrl_o    <= dec_ctrl;
      ex_imm_o     <= dec_imm;
      ex_rs1_o     <= rs1;
      ex_rs2_o     <= rs2;
      ex_rd_o      <= rd;
      ex_illegal_o <= dec_illegal;
    end else if (ex_ready_i) begin
      ex_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: reset, back-pressure, load-use bubble,
// flush, steady streaming and illegal/branch decode.
module tb_decode_pipe;
  import control_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, fetch_valid, flush, ex_ready;
  logic [31:0] fetch_pc, fetch_instr;
  logic        fetch_ready, ex_valid, ex_illegal;
  logic [31:0] ex_pc, ex_imm;
  ctrl_t       ex_ctrl;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  q_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  decode_pipe #(.INSTR_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .fetch_valid_i (fetch_valid),
    .fetch_ready_o (fetch_ready),
    .fetch_pc_i    (fetch_pc),
    .fetch_instr_i (fetch_instr),
    .flush_i       (flush),
    .ex_ready_i    (ex_ready),
    .ex_valid_o    (ex_valid),
    .ex_pc_o       (ex_pc),
    .ex_ctrl_o     (ex_ctrl),
    .ex_imm_o      (ex_imm),
    .ex_rs1_o      (ex_rs1),
    .ex_rs2_o      (ex_rs2),
    .ex_rd_o       (ex_rd),
    .ex_illegal_o  (ex_illegal),
    .q_count_o     (q_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Pushes i0 at pc 0x400 and i1 at 0x404 back-to-back with EX always ready,
  // recording ex_valid after each of five edges.
  task automatic run_pair(input logic [31:0] i0, input logic [31:0] i1,
                          output logic [4:0] vseq, output ctrl_t c1);
    fetch_valid = 1'b1; fetch_pc = 32'h400; fetch_instr = i0;
    cyc(); vseq[0] = ex_valid;
    fetch_pc = 32'h404; fetch_instr = i1;
    cyc(); vseq[1] = ex_valid; c1 = ex_ctrl;
    fetch_valid = 1'b0;
    for (int k = 2; k < 5; k++) begin
      cyc(); vseq[k] = ex_valid;
    end
  endtask

  logic [4:0] vseq;
  ctrl_t      c1;
  int         acc;
  logic       seen;

  initial begin
    rst_n = 1'b0; fetch_valid = 1'b0; flush = 1'b0; ex_ready = 1'b0;
    fetch_pc = '0; fetch_instr = '0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_valid", ex_valid, 0);
    chk("rst_count", q_count, 0);

    // 1: async reset with entries queued, then first instruction latency
    fetch_valid = 1'b1; fetch_instr = 32'h0000_0013;
    for (int i = 0; i < 3; i++) begin
      fetch_pc = 32'h100 + 32'(4*i);
      cyc();
    end
    fetch_valid = 1'b0;
    chk("pre_rst_count", q_count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", q_count, 0);
    chk("async_rst_valid", ex_valid, 0);
    chk("async_rst_pc", ex_pc, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    fetch_valid = 1'b1; fetch_pc = 32'h200; fetch_instr = 32'h0050_0093;
    cyc();
    fetch_valid = 1'b0;
    chk("lat_edge1_valid", ex_valid, 0);
    cyc();
    chk("addi_valid", ex_valid, 1);
    chk("addi_pc", ex_pc, 32'h200);
    chk("addi_imm", ex_imm, 5);
    chk("addi_rd", ex_rd, 1);
    chk("addi_rw", ex_ctrl.reg_write, 1);
    chk("addi_alusrc", ex_ctrl.alu_src, 1);
    chk("addi_aluctrl", ex_ctrl.alu_ctrl, ALU_ADD);
    chk("addi_illegal", ex_illegal, 0);
    ex_ready = 1'b1;
    cyc();
    chk("addi_consumed", ex_valid, 0);

    // 2: back-pressure fills queue, then in-order drain
    ex_ready = 1'b0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      fetch_valid = 1'b1; fetch_pc = 32'h300 + 32'(4*i); fetch_instr = 32'h0000_0013;
      #1 acc += int'(fetch_ready);
      cyc();
    end
    fetch_valid = 1'b0;
    chk("full_accepted", acc, 5);
    chk("full_count", q_count, 4);
    chk("full_ready", fetch_ready, 0);
    chk("full_ex_pc", ex_pc, 32'h300);
    ex_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      cyc();
      chk("drain_valid", ex_valid, 1);
      chk("drain_pc", ex_pc, 32'h300 + 32'(4*i));
    end
    cyc();
    chk("drain_end_valid", ex_valid, 0);
    chk("drain_end_count", q_count, 0);

    // 3: load-use bubbles (rs1, rs2) and non-dependent / LUI cases
    run_pair(32'h0001_2283, 32'h0012_8333, vseq, c1);
    chk("lu_rs1_seq", vseq, 5'b01010);
    chk("lw_result_src", c1.result_src, 1);
    chk("lw_mem_type", c1.mem_type, MT_WORD);
    run_pair(32'h0001_2283, 32'h0012_0333, vseq, c1);
    chk("lu_indep_seq", vseq, 5'b00110);
    run_pair(32'h0001_2283, 32'h0050_2023, vseq, c1);
    chk("lu_rs2_seq", vseq, 5'b01010);
    run_pair(32'h0001_2283, 32'h0002_B337, vseq, c1);
    chk("lu_lui_seq", vseq, 5'b00110);

    // 4: flush with a same-cycle fetch offer
    ex_ready = 1'b0;
    fetch_valid = 1'b1; fetch_instr = 32'h0000_0013;
    for (int i = 0; i < 4; i++) begin
      fetch_pc = 32'h500 + 32'(4*i);
      cyc();
    end
    chk("preflush_count", q_count, 3);
    chk("preflush_valid", ex_valid, 1);
    fetch_pc = 32'h5F0; flush = 1'b1;
    #1 chk("flush_ready", fetch_ready, 0);
    cyc();
    flush = 1'b0; fetch_valid = 1'b0;
    chk("flush_valid", ex_valid, 0);
    chk("flush_count", q_count, 0);
    ex_ready = 1'b1; seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      seen |= ex_valid;
    end
    chk("flush_no_issue", seen, 0);

    // 5: steady streaming, one bundle per cycle
    for (int i = 0; i < 22; i++) begin
      fetch_valid = 1'b1; fetch_pc = 32'h600 + 32'(4*i); fetch_instr = 32'h0000_0013;
      cyc();
      if (i >= 1) begin
        chk("stream_count", q_count, 1);
        chk("stream_valid", ex_valid, 1);
        chk("stream_pc", ex_pc, 32'h600 + 32'(4*(i-1)));
      end
    end
    fetch_valid = 1'b0;
    cyc(); cyc();
    chk("stream_end_valid", ex_valid, 0);

    // 6: illegal opcode, then a backward branch
    ex_ready = 1'b0;
    fetch_valid = 1'b1; fetch_pc = 32'h700; fetch_instr = 32'hFFFF_FFFF;
    cyc();
    fetch_valid = 1'b0;
    cyc();
    chk("ill_valid", ex_valid, 1);
    chk("ill_flag", ex_illegal, 1);
    chk("ill_ctrl", ex_ctrl, 0);
    chk("ill_rw", ex_ctrl.reg_write, 0);
    chk("ill_mw", ex_ctrl.mem_write, 0);
    chk("ill_br", ex_ctrl.branch, 0);
    chk("ill_jmp", ex_ctrl.jump, 0);
    ex_ready = 1'b1;
    fetch_valid = 1'b1; fetch_pc = 32'h704; fetch_instr = 32'hFE00_0EE3;
    cyc();
    fetch_valid = 1'b0;
    cyc();
    chk("beq_valid", ex_valid, 1);
    chk("beq_branch", ex_ctrl.branch, 1);
    chk("beq_imm", ex_imm, 32'hFFFF_FFFC);
    chk("beq_aluctrl", ex_ctrl.alu_ctrl, ALU_SUB);
    chk("beq_rw", ex_ctrl.reg_write, 0);
    chk("beq_illegal", ex_illegal, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
